n_shift_register: RTL and testbench
===================================

# n_shift_register

Parametrised successor to the plain N-bit register: an N-bit universal shift register with parallel load, clear, hold, logical/arithmetic shifts and rotates. It supports single-step operation every enabled clock and a multi-step mode where one `start` runs `amount` steps under a busy/done handshake. It sits in the datapath library beside the plain register, for serial/parallel conversion and shift-by-k operations.

## Interface
Parameters:
- `N`, 4: data width, ≥ 2.
- `AW`, 3: width of `amount`; maximum multi-step count is 2^AW − 1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  clock enable; 0 freezes all state except `done`.
- `mode`  in  3  operation select (see Operation).
- `x`  in  N  parallel load data.
- `sin`  in  1  serial fill bit for SHL/SHR.
- `start`  in  1  begin a multi-step operation.
- `amount`  in  AW  number of steps for `start`.
- `y`  out  N  register contents.
- `sout`  out  1  bit shifted out by the last step (registered).
- `busy`  out  1  multi-step run in progress.
- `done`  out  1  one-cycle pulse: multi-step run complete.

## Operation
- Modes:
  - 000 HOLD.
  - 001 LOAD: y←x.
  - 010 SHL: y←{y[N-2:0],sin}.
  - 011 SHR: y←{sin,y[N-1:1]}.
  - 100 ROL.
  - 101 ROR.
  - 110 ASR: MSB replicated.
  - 111 CLEAR: y←0.
- `sout` values:
  - SHL/ROL: old y[N-1].
  - SHR/ROR/ASR: old y[0].
  - LOAD/CLEAR: 0.
  - HOLD: unchanged.
- FSM states IDLE and RUN. Reset enters IDLE.
- IDLE, en=1, start=0: apply `mode` once per edge (continuous single-step).
- IDLE, en=1, start=1, amount≥1:
  - Latch mode and amount; apply the first step on this edge.
  - If amount=1: stay IDLE, set done.
  - Otherwise: go to RUN with remaining count = amount−1.
- IDLE, en=1, start=1, amount=0: y and sout unchanged; done set on this edge.
- `start` with a non-shift mode (HOLD/LOAD/CLEAR): op applied once, done set; RUN is not entered.
- RUN, en=1: apply the latched op and decrement the count. At the step where the count reaches 0, go to IDLE and set done.
- While in RUN, `mode`, `x`, `start` and `amount` are ignored.
- RUN, en=0: y, sout and count are frozen; busy stays 1.
- amount > N is legal: shifts saturate to the fill pattern; rotates wrap modulo N.

## Timing
- Reset values: y=0, sout=0, busy=0, done=0, state IDLE.
- `rst_n` low mid-run aborts the run immediately. No done pulse is produced for the aborted run.
- Single-step latency: 1 edge.
- Multi-step with amount=k≥1 and en held high:
  - Final y is visible after k edges from the start edge.
  - busy=1 for k−1 cycles.
  - done=1 for exactly the one cycle in which final y first appears.
- `done` is high for exactly one cycle and clears on the next edge regardless of `en`.
- Back-to-back: a new `start` is accepted on the edge where done is high, because the FSM is already in IDLE.
- busy = (state==RUN). It is registered, with no combinational input-to-output paths.

## Structure
- Shared package `shift_pkg`: mode constants MODE_HOLD … MODE_CLEAR, and FSM state encodings ST_IDLE and ST_RUN.
- One combinational sub-module `shift_step` (parameter N):
  - Inputs: y, mode, sin.
  - Outputs: next y, out bit.
- `shift_step` is reused by both the single-step and multi-step paths. The top level holds the FSM, counter, latched mode and registers.

## Test plan
All scenarios use N=8, AW=4.
- Reset: drive rst_n=0 asynchronously mid-run → y=0x00, sout=0, busy=0, done=0 before the next edge; no done follows.
- Single-step: LOAD x=0xA5, then HOLD for 3 cycles → y=0xA5 throughout; CLEAR → y=0x00, sout=0.
- Multi-step shift: y=0xA5, start SHL, amount=3, sin=0 → busy=1 for 2 cycles; on the 3rd edge y=0x28, sout=1, done=1 for one cycle.
- Arithmetic shift: y=0x90, start ASR, amount=2 → y=0xE4, sout=0, done after 2 edges.
- Stall and wrap: y=0x01, start ROR, amount=9, en=0 for 2 cycles mid-run → y=0x80; done 11 cycles after start; busy=1 for 10 cycles.
- Degenerate and back-to-back:
  - amount=0 start → y unchanged, done pulse next cycle, busy never 1.
  - New start issued during the done cycle is accepted.
  - start asserted during RUN is ignored.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// the two-state run controller encoding.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Only true shifts/rotates can span several steps; the rest finish in one.
  function automatic logic is_shift(input logic [2:0] m);
    return !(m == MODE_HOLD || m == MODE_LOAD || m == MODE_CLEAR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the shift register: next contents and the bit
// pushed out. LOAD is resolved by the caller, which owns the parallel data.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] y,
  input  logic [2:0]   mode,
  input  logic         sin,
  output logic [N-1:0] y_next,
  output logic         out_bit
);

  logic signed [N-1:0] y_s;

  always_comb begin
    y_s     = y;
    y_next  = y;
    out_bit = 1'b0;
    case (mode)
      MODE_HOLD:  y_next = y;
      MODE_LOAD:  y_next = y;
      MODE_SHL:   begin y_next = {y[N-2:0], sin};  out_bit = y[N-1]; end
      MODE_SHR:   begin y_next = {sin, y[N-1:1]};  out_bit = y[0];   end
      MODE_ROL:   begin y_next = {y[N-2:0], y[N-1]}; out_bit = y[N-1]; end
      MODE_ROR:   begin y_next = {y[0], y[N-1:1]}; out_bit = y[0];   end
      MODE_ASR:   begin y_next = y_s >>> 1;        out_bit = y[0];   end
      MODE_CLEAR: y_next = '0;
      default:    y_next = y;
    endcase
  end

endmodule

// File: rtl/n_shift_register.sv
// N-bit universal shift register with single-step operation and a counted
// multi-step run (start/amount) reported through busy and a done pulse.
module n_shift_register
  import shift_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  x,
  input  logic          sin,
  input  logic          start,
  input  logic [AW-1:0] amount,
  output logic [N-1:0]  y,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  y_d;
  logic          sout_d, done_d;

  logic [2:0]    step_mode;
  logic [N-1:0]  step_y;
  logic          step_out;

  // During a run the latched op drives the step, so live mode is ignored.
  assign step_mode = (state_q == ST_RUN) ? op_q : mode;

  shift_step #(.N(N)) u_step (
    .y       (y),
    .mode    (step_mode),
    .sin     (sin),
    .y_next  (step_y),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    y_d     = y;
    sout_d  = sout;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start && amount == '0) begin
            done_d = 1'b1;
          end else begin
            y_d = (mode == MODE_LOAD) ? x : step_y;
            if (mode != MODE_HOLD) sout_d = step_out;
            if (start) begin
              op_d = mode;
              if (is_shift(mode) && amount != AW'(1)) begin
                state_d = ST_RUN;
                cnt_d   = amount - AW'(1);
              end else begin
                done_d = 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          y_d    = step_y;
          sout_d = step_out;
          cnt_d  = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register stage: done is rewritten every edge so it never outlives one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MODE_HOLD;
      cnt_q   <= '0;
      y       <= '0;
      sout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      y       <= y_d;
      sout    <= sout_d;
      busy    <= (state_d == ST_RUN);
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_n_shift_register.sv
// Scenario bench for n_shift_register (N=8, AW=4): per-cycle stimulus tables,
// expected outputs queued when driven and compared after each edge.
module tb_n_shift_register;
  import shift_pkg::*;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [N-1:0]  x;
  logic          sin;
  logic          start;
  logic [AW-1:0] amount;
  logic [N-1:0]  y;
  logic          sout;
  logic          busy;
  logic          done;

  n_shift_register #(.N(N), .AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .x      (x),
    .sin    (sin),
    .start  (start),
    .amount (amount),
    .y      (y),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [2:0] mode;
    logic [7:0] x;
    logic       sin;
    logic       start;
    logic [3:0] amt;
    logic [7:0] ey;
    logic       es;
    logic       eb;
    logic       ed;
  } vec_t;

  logic [10:0] exp_q[$];
  logic [10:0] got, want;
  int nvec = 0;
  int nerr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    en     = v.en;
    mode   = v.mode;
    x      = v.x;
    sin    = v.sin;
    start  = v.start;
    amount = v.amt;
    exp_q.push_back({v.ey, v.es, v.eb, v.ed});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; x = '0; sin = 1'b0;
    start = 1'b0; amount = '0;
    #2;
    got = {y, sout, busy, done}; want = 11'h0; nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL reset: y/sout/busy/done=%h required %h", got, want);
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_step();
    vec_t tv [13];
    tv = '{
      '{1'b1, MODE_LOAD,  8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_HOLD,  8'h00, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_HOLD,  8'hFF, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_HOLD,  8'h00, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_CLEAR, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_LOAD,  8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_ROL,   8'h00, 1'b0, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0, 1'b0},
      '{1'b1, MODE_ROR,   8'h00, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0},
      '{1'b1, MODE_SHR,   8'h00, 1'b0, 1'b0, 4'd0, 8'h40, 1'b1, 1'b0, 1'b0},
      '{1'b1, MODE_HOLD,  8'h00, 1'b0, 1'b0, 4'd0, 8'h40, 1'b1, 1'b0, 1'b0},
      '{1'b1, MODE_SHL,   8'h00, 1'b1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0},
      '{1'b0, MODE_CLEAR, 8'h00, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_ASR,   8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0}
    };
    foreach (tv[i]) begin
      apply(tv[i]);
      tick();
      got = {y, sout, busy, done}; want = exp_q.pop_front(); nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL single[%0d]: y=%h sout=%b busy=%b done=%b required y=%h sout=%b busy=%b done=%b",
                 i, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_multi_shl();
    vec_t tv [5];
    tv = '{
      '{1'b1, MODE_LOAD,  8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_SHL,   8'h00, 1'b0, 1'b1, 4'd3, 8'h4A, 1'b1, 1'b1, 1'b0},
      '{1'b1, MODE_CLEAR, 8'h00, 1'b0, 1'b1, 4'd5, 8'h94, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_CLEAR, 8'h00, 1'b0, 1'b0, 4'd0, 8'h28, 1'b1, 1'b0, 1'b1},
      '{1'b1, MODE_HOLD,  8'h00, 1'b0, 1'b0, 4'd0, 8'h28, 1'b1, 1'b0, 1'b0}
    };
    foreach (tv[i]) begin
      apply(tv[i]);
      tick();
      got = {y, sout, busy, done}; want = exp_q.pop_front(); nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL multi_shl[%0d]: y=%h sout=%b busy=%b done=%b required y=%h sout=%b busy=%b done=%b",
                 i, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_asr();
    vec_t tv [4];
    tv = '{
      '{1'b1, MODE_LOAD, 8'h90, 1'b0, 1'b0, 4'd0, 8'h90, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_ASR,  8'h00, 1'b1, 1'b1, 4'd2, 8'hC8, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b1, 1'b0, 4'd0, 8'hE4, 1'b0, 1'b0, 1'b1},
      '{1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'hE4, 1'b0, 1'b0, 1'b0}
    };
    foreach (tv[i]) begin
      apply(tv[i]);
      tick();
      got = {y, sout, busy, done}; want = exp_q.pop_front(); nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL asr[%0d]: y=%h sout=%b busy=%b done=%b required y=%h sout=%b busy=%b done=%b",
                 i, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_stall_wrap();
    vec_t tv [13];
    tv = '{
      '{1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_ROR,  8'h00, 1'b0, 1'b1, 4'd9, 8'h80, 1'b1, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h40, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h20, 1'b0, 1'b1, 1'b0},
      '{1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h20, 1'b0, 1'b1, 1'b0},
      '{1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h20, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h10, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h08, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h04, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h02, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b1, 1'b0, 1'b1},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b1, 1'b0, 1'b0}
    };
    foreach (tv[i]) begin
      apply(tv[i]);
      tick();
      got = {y, sout, busy, done}; want = exp_q.pop_front(); nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL stall_wrap[%0d]: y=%h sout=%b busy=%b done=%b required y=%h sout=%b busy=%b done=%b",
                 i, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv [10];
    tv = '{
      '{1'b1, MODE_SHL,  8'h00, 1'b1, 1'b1, 4'd0, 8'h80, 1'b1, 1'b0, 1'b1},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b1, 1'b0, 1'b0},
      '{1'b1, MODE_SHR,  8'h00, 1'b0, 1'b1, 4'd2, 8'h40, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h20, 1'b0, 1'b0, 1'b1},
      '{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b1, 4'd2, 8'h40, 1'b0, 1'b1, 1'b0},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h80, 1'b0, 1'b0, 1'b1},
      '{1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0, 1'b1},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0},
      '{1'b1, MODE_SHL,  8'h00, 1'b1, 1'b1, 4'd1, 8'hB5, 1'b0, 1'b0, 1'b1},
      '{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'hB5, 1'b0, 1'b0, 1'b0}
    };
    foreach (tv[i]) begin
      apply(tv[i]);
      tick();
      got = {y, sout, busy, done}; want = exp_q.pop_front(); nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL back_to_back[%0d]: y=%h sout=%b busy=%b done=%b required y=%h sout=%b busy=%b done=%b",
                 i, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    apply('{1'b1, MODE_SHR, 8'h00, 1'b1, 1'b1, 4'd10, 8'hDA, 1'b1, 1'b1, 1'b0});
    tick();
    start = 1'b0;
    got = {y, sout, busy, done}; want = exp_q.pop_front(); nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL midrun_start: y/sout/busy/done=%h required %h", got, want);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {y, sout, busy, done}; want = 11'h0; nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL midrun_async_reset: y/sout/busy/done=%h required %h", got, want);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply('{1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0});
      tick();
      got = {y, sout, busy, done}; want = exp_q.pop_front(); nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL post_reset[%0d]: y/sout/busy/done=%h required %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_multi_shl();
    test_asr();
    test_stall_wrap();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
